wb_trace_buffer: RTL

Parametrised retire-trace capture buffer for the miniLA cores. It replaces the single-entry write-back debug register with a circular FIFO of retired-instruction records: PC, write-enable, destination register and write-back value. Capture is gated by a PC trigger, and the buffer runs in stop-on-full or overwrite-oldest mode. It sits beside the core on the write-back trace signals; the board debug logic or the testbench drains it through a valid/ready port.

---
 rtl/trace_pkg.sv | 25 ++
 rtl/trace_ram.sv | 23 ++
 rtl/wb_trace_buffer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and constants for the retire-trace buffer
package trace_pkg;

  localparam int REG_W = 5;
  localparam int TS_W  = 32;

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_RUN   = 2'd1,
    ST_STOP  = 2'd2
  } state_e;

  // Record layout at the default 32-bit PC and data widths; the buffer builds
  // its own copy of this layout sized by its parameters.
  typedef struct packed {
    logic [31:0]      pc;
    logic             ena;
    logic [REG_W-1:0] rd;
    logic [31:0]      value;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]  ts;
`endif
  } trace_rec_t;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - record storage, one synchronous write port and one asynchronous read port
module trace_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; validity is tracked by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - triggered circular retire-trace FIFO; TRACE_TIMESTAMP_EN adds per-record cycle stamps
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PC_W      = 32,
  parameter int DATA_W    = 32,
  parameter int OVERWRITE = 0,
  parameter int CNT_W     = 16
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc,
  input  logic                       in_ena,
  input  logic [REG_W-1:0]           in_reg,
  input  logic [DATA_W-1:0]          in_value,
  input  logic                       trig_en,
  input  logic [PC_W-1:0]            trig_pc,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic                       out_ena,
  output logic [REG_W-1:0]           out_reg,
  output logic [DATA_W-1:0]          out_value,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_W-1:0]           overflow_cnt,
  output logic [1:0]                 state
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]            out_ts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [CNT_W-1:0] OVF_ONE = CNT_W'(1);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              ena;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] value;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
  } rec_t;

  state_e            state_q, state_d;
  logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [AW:0]       count_q, count_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d;
  logic              push_acc, pop, wr_en, ovr, drop, is_full, is_empty;
  rec_t              wr_rec, rd_rec, head_rec;

  assign is_full  = (count_q == DEPTH_C);
  assign is_empty = (count_q == '0);
  assign pop      = !is_empty && out_ready;

  // Decide whether the incoming record is accepted and how a full buffer handles it.
  always_comb begin
    push_acc = 1'b0;
    case (state_q)
      ST_ARMED: push_acc = in_valid && (!trig_en || (in_pc == trig_pc));
      ST_RUN:   push_acc = in_valid;
      default:  push_acc = 1'b0;
    endcase
    wr_en = push_acc && !clear && (!is_full || pop || (OVERWRITE != 0));
    ovr   = push_acc && is_full && !pop && (OVERWRITE != 0);
    drop  = push_acc && is_full && !pop && (OVERWRITE == 0);
  end

  // Next-state for FSM, pointers, occupancy and overflow counter; clear beats push and pop.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = ST_ARMED;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ovf_d   = '0;
    end else begin
      if (state_q == ST_ARMED && push_acc) state_d = ST_RUN;
      if (drop)                            state_d = ST_STOP;
      if (wr_en)                           tail_d  = tail_q + PTR_ONE;
      if (pop || ovr)                      head_d  = head_q + PTR_ONE;
      if ((drop || ovr) && ovf_q != '1)    ovf_d   = ovf_q + OVF_ONE;
      if (wr_en && !ovr && !pop)           count_d = count_q + CNT_ONE;
      else if (pop && !wr_en)              count_d = count_q - CNT_ONE;
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= ST_ARMED;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running cycle stamp; wraps naturally and is not affected by clear.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) ts_q <= '0;
    else         ts_q <= ts_q + TS_W'(1);
  end
`endif

  // Pack the incoming record and mask the head record to zero while empty.
  always_comb begin
    wr_rec       = '0;
    wr_rec.pc    = in_pc;
    wr_rec.ena   = in_ena;
    wr_rec.rd    = in_reg;
    wr_rec.value = in_value;
`ifdef TRACE_TIMESTAMP_EN
    wr_rec.ts    = ts_q;
`endif
    head_rec     = is_empty ? '0 : rd_rec;
  end

  trace_ram #(
    .W     ($bits(rec_t)),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (cpu_clk),
    .we_i    (wr_en),
    .waddr_i (tail_q),
    .wdata_i (wr_rec),
    .raddr_i (head_q),
    .rdata_o (rd_rec)
  );

  assign out_valid    = !is_empty;
  assign out_pc       = head_rec.pc;
  assign out_ena      = head_rec.ena;
  assign out_reg      = head_rec.rd;
  assign out_value    = head_rec.value;
`ifdef TRACE_TIMESTAMP_EN
  assign out_ts       = head_rec.ts;
`endif
  assign count        = count_q;
  assign full         = is_full;
  assign empty        = is_empty;
  assign overflow_cnt = ovf_q;
  assign state        = state_q;

endmodule
